// File: rtl/rom_loader.sv
// Boot ROM image loader: parses MAGIC, LEN, payload and checksum from a byte stream,
// writes the payload into program RAM and releases the CPU once the image verifies.
module rom_loader #(
    parameter int unsigned RAM_ADDR_WIDTH = 12,
    parameter logic [7:0]  MAGIC          = 8'hA5
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      byte_valid_in,
    input  logic [7:0]                byte_in,
    input  logic                      stream_done_in,
    output logic                      ram_we_out,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr_out,
    output logic [7:0]                ram_data_out,
    output logic                      cpu_rst_out,
    output logic                      load_done_out,
    output logic [2:0]                error_out
);

    typedef enum logic [2:0] {
        MAGIC_S,
        LEN_LO_S,
        LEN_HI_S,
        PAYLOAD_S,
        CHECK_S,
        DONE_S,
        ERROR_S
    } state_t;

    localparam logic [2:0]  ErrMagic = 3'd1;
    localparam logic [2:0]  ErrLen   = 3'd2;
    localparam logic [2:0]  ErrTrunc = 3'd3;
    localparam logic [2:0]  ErrSum   = 3'd4;
    localparam logic [32:0] MaxLen   = 33'd1 << RAM_ADDR_WIDTH;

    state_t      state_q;
    logic [15:0] len_q;
    logic [16:0] count_q;
    logic [7:0]  sum_q;

    logic [15:0] len_full;
    logic [16:0] count_inc;
    logic        parsing;
    logic        truncated;

    assign len_full  = {byte_in, len_q[7:0]};
    assign count_inc = count_q + 17'd1;
    assign parsing   = (state_q != DONE_S) && (state_q != ERROR_S);
    // A byte that arrives together with stream_done_in still counts.
    assign truncated = parsing && stream_done_in && !byte_valid_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= MAGIC_S;
            len_q         <= '0;
            count_q       <= '0;
            sum_q         <= '0;
            ram_we_out    <= 1'b0;
            ram_addr_out  <= '0;
            ram_data_out  <= '0;
            cpu_rst_out   <= 1'b1;
            load_done_out <= 1'b0;
            error_out     <= '0;
        end else begin
            ram_we_out <= 1'b0;
            if (truncated) begin
                state_q   <= ERROR_S;
                error_out <= ErrTrunc;
            end else if (byte_valid_in) begin
                case (state_q)
                    MAGIC_S: begin
                        if (byte_in == MAGIC) begin
                            state_q <= LEN_LO_S;
                        end else begin
                            state_q   <= ERROR_S;
                            error_out <= ErrMagic;
                        end
                    end
                    LEN_LO_S: begin
                        len_q   <= {8'h00, byte_in};
                        state_q <= LEN_HI_S;
                    end
                    LEN_HI_S: begin
                        len_q <= len_full;
                        if (len_full == 16'd0 || {17'd0, len_full} > MaxLen) begin
                            state_q   <= ERROR_S;
                            error_out <= ErrLen;
                        end else begin
                            ram_addr_out <= '0;
                            count_q      <= '0;
                            sum_q        <= '0;
                            state_q      <= PAYLOAD_S;
                        end
                    end
                    PAYLOAD_S: begin
                        ram_we_out   <= 1'b1;
                        ram_data_out <= byte_in;
                        ram_addr_out <= count_q[RAM_ADDR_WIDTH-1:0];
                        count_q      <= count_inc;
                        sum_q        <= sum_q + byte_in;
                        if (count_inc == {1'b0, len_q}) begin
                            state_q <= CHECK_S;
                        end
                    end
                    CHECK_S: begin
                        if (byte_in == sum_q) begin
                            state_q       <= DONE_S;
                            load_done_out <= 1'b1;
                            cpu_rst_out   <= 1'b0;
                        end else begin
                            state_q   <= ERROR_S;
                            error_out <= ErrSum;
                        end
                    end
                    default: begin
                        // DONE_S and ERROR_S hold until reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The module SHALL have parameter RAM_ADDR_WIDTH, default 12, meaning the program RAM address width in bits.
REQ-002 The module SHALL have parameter MAGIC, default 8'hA5, meaning the required first image byte.
REQ-003 The module SHALL have port clk_in, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_in, input, 1 bit, meaning the reset; it is synchronous and active-high.
REQ-005 The module SHALL have port byte_valid_in, input, 1 bit, meaning byte_in is valid this cycle (single-cycle pulse, back-to-back allowed).
REQ-006 The module SHALL have port byte_in, input, 8 bits, meaning a ROM image byte from the upstream ROM reader.
REQ-007 The module SHALL have port stream_done_in, input, 1 bit, meaning the level "upstream has delivered its last byte"; it may rise in the same cycle as the last byte_valid_in.
REQ-008 The module SHALL have port ram_we_out, input-free output, 1 bit, meaning the program RAM write enable, one cycle per payload byte.
REQ-009 The module SHALL have port ram_addr_out, output, RAM_ADDR_WIDTH bits, meaning the program RAM write address.
REQ-010 The module SHALL have port ram_data_out, output, 8 bits, meaning the program RAM write data.
REQ-011 The module SHALL have port cpu_rst_out, output, 1 bit, meaning CPU hold-in-reset.
REQ-012 The module SHALL have port load_done_out, output, 1 bit, meaning the image loaded and verified.
REQ-013 The module SHALL have port error_out, output, 3 bits, meaning the error code: 0 none, 1 bad magic, 2 bad length, 3 truncated, 4 checksum mismatch.

Function
REQ-014 The image format SHALL be: MAGIC, LEN_LO, LEN_HI, then LEN payload bytes, then one checksum byte equal to the mod-256 sum of the payload bytes.
REQ-015 The FSM states SHALL be MAGIC_S, LEN_LO_S, LEN_HI_S, PAYLOAD_S, CHECK_S, DONE_S and ERROR_S; each byte_valid_in advances parsing by exactly one byte.
REQ-016 In MAGIC_S, on a valid byte: if it equals MAGIC, go to LEN_LO_S; otherwise go to ERROR_S with code 1.
REQ-017 LEN_LO_S and LEN_HI_S SHALL capture the 16-bit length; in LEN_HI_S, if LEN==0 or LEN > 2**RAM_ADDR_WIDTH, go to ERROR_S with code 2; otherwise clear the address, the byte counter and the sum, then go to PAYLOAD_S.
REQ-018 In PAYLOAD_S, each valid byte SHALL produce, on the next cycle, ram_we_out=1 with ram_data_out=byte and ram_addr_out=count, followed by count+1 and sum+byte (8-bit wrap).
REQ-019 Latency SHALL be exactly 1 cycle from byte_valid_in to ram_we_out; back-to-back valid bytes SHALL produce back-to-back writes with consecutive addresses.
REQ-020 After the LEN-th payload byte the FSM SHALL go to CHECK_S; the checksum byte SHALL NOT be written to RAM.
REQ-021 In CHECK_S, on a valid byte: if byte==sum, go to DONE_S; otherwise go to ERROR_S with code 4.
REQ-022 Truncation: in MAGIC_S through CHECK_S, a cycle with stream_done_in=1 and byte_valid_in=0 SHALL cause ERROR_S with code 3; a byte arriving in the same cycle as stream_done_in SHALL be processed normally.
REQ-023 DONE_S and ERROR_S SHALL be terminal until reset; bytes arriving in these states SHALL be ignored and SHALL cause no RAM writes.
REQ-024 load_done_out SHALL be 1 exactly when the FSM is in DONE_S; cpu_rst_out SHALL be 1 in every state except DONE_S.
REQ-025 error_out SHALL be registered, non-zero only in ERROR_S, and SHALL hold the first error code detected.
REQ-026 ram_we_out SHALL be 0 in every cycle without a payload write.

Reset
REQ-027 While rst_in=1 the module SHALL enter MAGIC_S and drive ram_we_out=0, ram_addr_out=0, ram_data_out=0, load_done_out=0, error_out=0, cpu_rst_out=1, and clear the length, counter and sum.
REQ-028 Reset asserted mid-load SHALL abort the load in the next cycle with no further RAM writes; a fresh image SHALL then parse from MAGIC_S.

Verification
REQ-029 A bench SHALL apply the stream A5,03,00,10,20,30,60 back-to-back, then stream_done_in, and SHALL observe writes (0,10),(1,20),(2,30), then load_done_out=1, cpu_rst_out=0 and error_out=0.
REQ-030 A bench SHALL apply a first byte of 5A and SHALL observe error_out=1, no RAM writes and cpu_rst_out=1.
REQ-031 A bench SHALL apply A5,00,00 and, for RAM_ADDR_WIDTH=12, A5,01,10 (LEN=4097), and SHALL observe error_out=2 in both cases.
REQ-032 A bench SHALL apply A5,02,00,FF then stream_done_in=1 with no more bytes, and SHALL observe one write (0,FF) then error_out=3.
REQ-033 A bench SHALL apply A5,02,00,FF,02,00 and SHALL observe error_out=4 (sum 01 is not 00); a correct trailing 01 in place of 00 SHALL instead give load_done_out=1.
REQ-034 A bench SHALL apply rst_in for one cycle after the second payload byte of the REQ-029 image, then the full image again, and SHALL observe no writes during or after the reset until the new payload, followed by a successful load.
